// File: rtl/circuit1_seq.sv
// Sequential evaluator: z = min(a+b, a+c), x = a*c - (a+b), using one shared adder/subtractor and one multiplier.
// Optional overflow flag output ovf is enabled by defining CIRCUIT1_SEQ_OVF_EN.
module circuit1_seq #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] z,
    output logic [DATAWIDTH-1:0] x
`ifdef CIRCUIT1_SEQ_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] S_D    = 3'd1;
    localparam logic [2:0] S_E    = 3'd2;
    localparam logic [2:0] S_CMP  = 3'd3;
    localparam logic [2:0] S_MUL  = 3'd4;
    localparam logic [2:0] S_SUB  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]           state_q, state_d;
    logic [DATAWIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [DATAWIDTH-1:0] d_q, d_d, e_q, e_d, f_q, f_d;
    logic [DATAWIDTH-1:0] z_q, z_d, x_q, x_d;

    // Shared adder/subtractor operand selection
    logic [DATAWIDTH-1:0] add_a, add_b, add_b_eff, sum, f_val;
    logic                 add_sub;

    always_comb begin
        add_a   = a_q;
        add_b   = b_q;
        add_sub = 1'b0;
        case (state_q)
            S_E: begin
                add_b = c_q;
            end
            S_SUB: begin
                add_a   = f_q;
                add_b   = d_q;
                add_sub = 1'b1;
            end
            default: ;
        endcase
        add_b_eff = add_sub ? ~add_b : add_b;
    end

`ifdef CIRCUIT1_SEQ_OVF_EN
    logic [DATAWIDTH:0]     sum_ext;
    logic [2*DATAWIDTH-1:0] prod;
    logic                   carry, mul_ovf;
    logic                   ovf_acc_q, ovf_acc_d, ovf_q, ovf_d;

    assign sum_ext = {1'b0, add_a} + {1'b0, add_b_eff} + (DATAWIDTH+1)'(add_sub);
    assign sum     = sum_ext[DATAWIDTH-1:0];
    assign carry   = sum_ext[DATAWIDTH];
    assign prod    = {{DATAWIDTH{1'b0}}, a_q} * {{DATAWIDTH{1'b0}}, c_q};
    assign f_val   = prod[DATAWIDTH-1:0];
    assign mul_ovf = |prod[2*DATAWIDTH-1:DATAWIDTH];
    assign ovf     = ovf_q;
`else
    assign sum   = add_a + add_b_eff + DATAWIDTH'(add_sub);
    assign f_val = a_q * c_q;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        e_d     = e_q;
        f_d     = f_q;
        z_d     = z_q;
        x_d     = x_q;
`ifdef CIRCUIT1_SEQ_OVF_EN
        ovf_acc_d = ovf_acc_q;
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = c;
                    state_d = S_D;
`ifdef CIRCUIT1_SEQ_OVF_EN
                    ovf_acc_d = 1'b0;
                    ovf_d     = 1'b0;
`endif
                end
            end
            S_D: begin
                d_d     = sum;
                state_d = S_E;
`ifdef CIRCUIT1_SEQ_OVF_EN
                ovf_acc_d = ovf_acc_q | carry;
`endif
            end
            S_E: begin
                e_d     = sum;
                state_d = S_CMP;
`ifdef CIRCUIT1_SEQ_OVF_EN
                ovf_acc_d = ovf_acc_q | carry;
`endif
            end
            S_CMP: begin
                // g = d > e; a tie selects d
                z_d     = (d_q > e_q) ? e_q : d_q;
                state_d = S_MUL;
            end
            S_MUL: begin
                f_d     = f_val;
                state_d = S_SUB;
`ifdef CIRCUIT1_SEQ_OVF_EN
                ovf_acc_d = ovf_acc_q | mul_ovf;
`endif
            end
            S_SUB: begin
                x_d     = sum;
                state_d = S_DONE;
`ifdef CIRCUIT1_SEQ_OVF_EN
                ovf_d = ovf_acc_q | ~carry;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            f_q     <= '0;
            z_q     <= '0;
            x_q     <= '0;
`ifdef CIRCUIT1_SEQ_OVF_EN
            ovf_acc_q <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            e_q     <= e_d;
            f_q     <= f_d;
            z_q     <= z_d;
            x_q     <= x_d;
`ifdef CIRCUIT1_SEQ_OVF_EN
            ovf_acc_q <= ovf_acc_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == S_DONE);
    assign z    = z_q;
    assign x    = x_q;

endmodule

// File: tb/tb_circuit1_seq.sv
// Self-checking bench for circuit1_seq: arithmetic reference model compared every cycle plus directed literal checks.
module tb_circuit1_seq;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0, c = '0;
    logic       busy, done;
    logic [7:0] z, x;
`ifdef CIRCUIT1_SEQ_OVF_EN
    logic       ovf;
`endif

    int errors = 0;
    int checks = 0;

    circuit1_seq #(.DATAWIDTH(8)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .busy  (busy),
        .done  (done),
        .z     (z),
        .x     (x)
`ifdef CIRCUIT1_SEQ_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1..6 = cycles since acceptance.
    int ph = 0;
    int z_old = 0, x_old = 0, z_new = 0, x_new = 0;
    int ovf_old = 0, ovf_new = 0;

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ph = 0;
            z_old = 0; x_old = 0; z_new = 0; x_new = 0;
            ovf_old = 0; ovf_new = 0;
        end else if (ph == 0) begin
            if (start) begin
                int ia, ib, ic, d, e, f;
                ia = int'(a); ib = int'(b); ic = int'(c);
                d = (ia + ib) % 256;
                e = (ia + ic) % 256;
                f = (ia * ic) % 256;
                z_new = (d > e) ? e : d;
                x_new = (f - d + 256) % 256;
                ovf_new = ((ia + ib > 255) || (ia + ic > 255) || (ia * ic > 255) || (f < d)) ? 1 : 0;
                ph = 1;
            end
        end else if (ph == 6) begin
            ph = 0;
            z_old = z_new; x_old = x_new; ovf_old = ovf_new;
        end else begin
            ph = ph + 1;
        end
    end

    always @(negedge Clk) begin
        check("busy", busy, (ph != 0) ? 1 : 0);
        check("done", done, (ph == 6) ? 1 : 0);
        check("z", z, (ph >= 4) ? z_new : z_old);
        check("x", x, (ph == 6) ? x_new : x_old);
`ifdef CIRCUIT1_SEQ_OVF_EN
        check("ovf", ovf, (ph == 6) ? ovf_new : ((ph == 0) ? ovf_old : 0));
`endif
    end

    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic,
                          input int ez, input int ex, input int eovf,
                          input bit b2b, input bit disturb);
        int n;
        if (!b2b) begin
            for (int k = 0; k < 10 && busy; k++) begin
                @(posedge Clk); #1;
            end
        end
        a = ia; b = ib; c = ic; start = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            n++;
            if (done) break;
            if (busy) start = 1'b0;
            if (disturb && n == 2) begin
                start = 1'b1;
                a = ~a; b = 8'hAA; c = 8'h55;
            end
        end
        start = 1'b0;
        check("latency", n, b2b ? 7 : 6);
        check("z_lit", z, ez);
        check("x_lit", x, ex);
`ifdef CIRCUIT1_SEQ_OVF_EN
        check("ovf_lit", ovf, eovf);
`endif
        $display("op a=%0d b=%0d c=%0d -> z=%0d x=%0d latency=%0d (want z=%0d x=%0d ovf=%0d)",
                 ia, ib, ic, z, x, n, ez, ex, eovf);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_z", z, 0);
        check("rst_x", x, 0);
        @(posedge Clk); #2;
        Rst = 1'b1;

        run_op(8'd3,   8'd4,   8'd5,  7,   8,   0, 1'b0, 1'b0);
        run_op(8'd200, 8'd100, 8'd10, 44,  164, 1, 1'b0, 1'b0);
        run_op(8'd1,   8'd5,   8'd1,  2,   251, 1, 1'b0, 1'b0);
        run_op(8'd2,   8'd3,   8'd3,  5,   1,   0, 1'b0, 1'b0);
        run_op(8'd255, 8'd1,   8'd2,  0,   254, 1, 1'b1, 1'b0);
        run_op(8'd3,   8'd4,   8'd5,  7,   8,   0, 1'b0, 1'b1);

        // Abandon an evaluation in S_MUL with an asynchronous reset
        for (int k = 0; k < 10 && busy; k++) begin
            @(posedge Clk); #1;
        end
        a = 8'd10; b = 8'd20; c = 8'd3; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            start = 1'b0;
        end
        check("mid_busy", busy, 1);
        Rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_z", z, 0);
        check("arst_x", x, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            check("arst_nodone", done, 0);
        end
        $display("op reset asserted in S_MUL, evaluation abandoned");
        @(posedge Clk); #2;
        Rst = 1'b1;
        run_op(8'd100, 8'd27, 8'd2, 102, 73, 0, 1'b0, 1'b0);

        @(posedge Clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
